prog_loader: RTL and testbench
==============================

# prog_loader

Sequential program loader that writes an instruction stream into the instruction memory and sequences the CPU reset around it. It replaces hand-driven programming: it halts the CPU, steers the address mux to the programming port and writes words from a valid/ready stream. It then optionally reads the memory back against a checksum and releases the CPU after a programmable delay. It sits between a host/boot source and the `memory`/`mux_2to1`/`cpu_4bit` trio. Address width, word width and delays are parametrised.

## Interface
- `ADDR_WIDTH`, 4: instruction memory address width; depth = 2^ADDR_WIDTH.
- `INSTR_WIDTH`, 8: instruction word width; matches `instruction_t`.
- `HALT_CYCLES`, 2: cycles CPU reset is held before the first write; must be ≥1.
- `RELEASE_CYCLES`, 1: cycles between dropping `prog_enable` and dropping `cpu_hold`; must be ≥1.
- `VERIFY`, 1: 1 enables the readback checksum phase; 0 skips it.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle pulse that begins a load; accepted in IDLE, RUN and ERROR; ignored elsewhere.
- `in_valid` in 1: stream word valid.
- `in_ready` out 1: loader accepts a word this cycle.
- `in_data` in INSTR_WIDTH: instruction word.
- `in_last` in 1: marks the final word of the program.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_WIDTH: memory address on the programming side of the mux.
- `mem_wdata` out INSTR_WIDTH: write data.
- `mem_rdata` in INSTR_WIDTH: memory read data; combinational, same cycle as `mem_addr`.
- `prog_enable` out 1: mux select; 1 routes `mem_addr` to memory.
- `cpu_hold` out 1: drives CPU reset.
- `busy` out 1: high in HALT, LOAD, VERIFY and RELEASE.
- `done` out 1: one-cycle pulse on entering RUN.
- `error` out 1: high while in ERROR.
- `err_code` out 2: 01 means overflow; 10 means checksum mismatch; 00 otherwise.

## Operation
- States:
  - IDLE is the reset state.
  - HALT: `cpu_hold`=1, `prog_enable`=1; a counter waits HALT_CYCLES, then goes to LOAD.
  - LOAD:
    - `in_ready`=1.
    - Each handshake (`in_valid`&`in_ready`) drives `mem_we`=1, `mem_addr`=wr_ptr and `mem_wdata`=`in_data` combinationally.
    - Each handshake increments wr_ptr, adds the word into `wsum` (mod 2^INSTR_WIDTH) and increments `count` (ADDR_WIDTH+1 bits).
    - A handshake with `in_last` goes to VERIFY, or to RELEASE if VERIFY=0.
  - VERIFY:
    - `mem_addr`=rd_ptr, counting 0..count-1, one word per cycle.
    - Each word is added into `rsum`.
    - After the last word, `rsum`==`wsum` goes to RELEASE; otherwise ERROR with code 10.
  - RELEASE: `prog_enable`=0 while `cpu_hold` stays 1 for RELEASE_CYCLES; then RUN.
  - RUN: `cpu_hold`=0, `prog_enable`=0, `done` pulses on entry; `start` goes to HALT.
  - ERROR: `cpu_hold`=1, `prog_enable`=0, `error`=1; `start` goes to HALT; no other exit except reset.
- Entry to HALT clears wr_ptr, rd_ptr, `count`, `wsum`, `rsum` and `err_code`.
- Overflow: a handshake arriving when `count`==2^ADDR_WIDTH without a prior `in_last` is not written (`mem_we`=0) and goes to ERROR with code 01. Exactly 2^ADDR_WIDTH words, the last one flagged `in_last`, is legal.
- No zero-length program exists; `in_last` on the first word loads one word.
- `in_valid` low in LOAD stalls indefinitely; no timeout.
- `start` while `busy` is ignored.
- Reset mid-operation: asynchronous return to IDLE. Memory contents are undefined and the CPU stays held.

## Timing
- Reset values:
  - state=IDLE.
  - `cpu_hold`=1, `prog_enable`=0.
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `busy`=0, `done`=0, `error`=0, `err_code`=00.
- `start` sampled at edge t: HALT from t+1; `prog_enable`/`cpu_hold` registered, valid from t+1.
- First `in_ready` appears HALT_CYCLES cycles after entering HALT.
- LOAD sustains one word per cycle. The write is committed at the edge where the handshake is sampled.
- VERIFY takes `count` cycles; the compare is registered, so the result is effective one cycle after the last read.
- `cpu_hold` falls exactly RELEASE_CYCLES cycles after `prog_enable` falls. `prog_enable` never falls while `mem_we` is 1.
- Best-case latency from `start` to `done` for N words with VERIFY=1: 1 + HALT_CYCLES + N + N + 1 + RELEASE_CYCLES.

## Structure
- Shared package `custom_types`: add `loader_state_t` enum (IDLE, HALT, LOAD, VERIFY, RELEASE, RUN, ERROR) and `loader_err_t` (ERR_NONE, ERR_OVERFLOW, ERR_CHECKSUM).
- One natural sub-module: `delay_counter`, a loadable down-counter with a zero flag, parametrised by width. It is instantiated for HALT and for RELEASE.
- The checksum accumulators and pointers are inline.

## Test plan
- **Basic load:** defaults, 12-word program 0x00..0x0B with `in_last` on word 12.
  - Memory holds 0x00..0x0B; `wsum`=`rsum`=0x42.
  - `done` pulses once and `cpu_hold` falls 1 cycle after `prog_enable` falls.
- **Backpressure:** same program with `in_valid` toggling 1,0,1,0…
  - Identical memory contents.
  - `mem_we` is high only on valid cycles.
- **Full depth:** 16 words, `in_last` on word 16 → RUN with no error. Word 17 instead of `in_last` → ERROR, `err_code`=01, the word is not written, `cpu_hold`=1.
- **Checksum fault:** force `mem_rdata` bit 0 of address 3 stuck at 1 while the word is 0x02 → ERROR, `err_code`=10, `prog_enable`=0. A subsequent `start` restarts cleanly.
- **Reset mid-LOAD:** assert `reset` after 5 words → same delta cycle: IDLE, `cpu_hold`=1, `in_ready`=0. After deassertion, `start` + a 3-word load completes normally.
- **Reload from RUN:** `start` while RUN → `cpu_hold`=1 next cycle, then a second program loads. `start` pulses while `busy` are ignored.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: loader FSM states, error codes and
// a width helper for the cycle-delay counters.
package custom_types;

    typedef logic [7:0] instruction_t;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_HALT,
        LD_LOAD,
        LD_VERIFY,
        LD_RELEASE,
        LD_RUN,
        LD_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_OVERFLOW = 2'b01,
        ERR_CHECKSUM = 2'b10
    } loader_err_t;

    // Bits needed to hold (cycles-1), never less than one.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/prog_loader_delay_counter.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module delay_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/prog_loader.sv
// Program loader: halts the CPU, streams a program into instruction memory,
// optionally verifies it by readback checksum, then releases the CPU.
module prog_loader
    import custom_types::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int INSTR_WIDTH    = 8,
    parameter int HALT_CYCLES    = 2,
    parameter int RELEASE_CYCLES = 1,
    parameter int VERIFY         = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INSTR_WIDTH-1:0] mem_wdata,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   prog_enable,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code
);

    localparam int HW = cnt_width(HALT_CYCLES);
    localparam int RW = cnt_width(RELEASE_CYCLES);

    loader_state_t          state;
    loader_err_t            err_q;
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH:0]    rd_idx;
    logic [ADDR_WIDTH:0]    count;
    logic [INSTR_WIDTH-1:0] wsum;
    logic [INSTR_WIDTH-1:0] rsum;
    logic                   cmp_pend;
    logic                   halt_zero;
    logic                   rel_zero;
    logic                   full;

    // Counters reload continuously outside their state, so they start
    // counting from (N-1) on the entry edge.
    delay_counter #(.WIDTH(HW)) u_halt_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state != LD_HALT),
        .load_val (HW'(HALT_CYCLES - 1)),
        .zero     (halt_zero)
    );

    delay_counter #(.WIDTH(RW)) u_rel_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state != LD_RELEASE),
        .load_val (RW'(RELEASE_CYCLES - 1)),
        .zero     (rel_zero)
    );

    assign full      = count[ADDR_WIDTH];
    assign mem_we    = (state == LD_LOAD) && in_valid && !full;
    assign mem_wdata = mem_we ? in_data : '0;
    assign err_code  = err_q;

    always_comb begin
        mem_addr = '0;
        if (state == LD_LOAD)
            mem_addr = wr_ptr;
        else if (state == LD_VERIFY)
            mem_addr = rd_idx[ADDR_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LD_IDLE;
            err_q       <= ERR_NONE;
            wr_ptr      <= '0;
            rd_idx      <= '0;
            count       <= '0;
            wsum        <= '0;
            rsum        <= '0;
            cmp_pend    <= 1'b0;
            cpu_hold    <= 1'b1;
            prog_enable <= 1'b0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LD_IDLE, LD_RUN, LD_ERROR: begin
                    if (start) begin
                        state       <= LD_HALT;
                        err_q       <= ERR_NONE;
                        wr_ptr      <= '0;
                        rd_idx      <= '0;
                        count       <= '0;
                        wsum        <= '0;
                        rsum        <= '0;
                        cmp_pend    <= 1'b0;
                        cpu_hold    <= 1'b1;
                        prog_enable <= 1'b1;
                        busy        <= 1'b1;
                        error       <= 1'b0;
                    end
                end
                LD_HALT: begin
                    if (halt_zero) begin
                        state    <= LD_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                LD_LOAD: begin
                    if (in_valid) begin
                        if (full) begin
                            state       <= LD_ERROR;
                            err_q       <= ERR_OVERFLOW;
                            in_ready    <= 1'b0;
                            prog_enable <= 1'b0;
                            busy        <= 1'b0;
                            error       <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            wsum   <= wsum + in_data;
                            count  <= count + 1'b1;
                            if (in_last) begin
                                in_ready <= 1'b0;
                                if (VERIFY != 0) begin
                                    state <= LD_VERIFY;
                                end else begin
                                    state       <= LD_RELEASE;
                                    prog_enable <= 1'b0;
                                end
                            end
                        end
                    end
                end
                LD_VERIFY: begin
                    // Reads run for count cycles, then one registered compare cycle.
                    if (!cmp_pend) begin
                        rsum   <= rsum + mem_rdata;
                        rd_idx <= rd_idx + 1'b1;
                        if (rd_idx == count - 1'b1)
                            cmp_pend <= 1'b1;
                    end else begin
                        cmp_pend    <= 1'b0;
                        prog_enable <= 1'b0;
                        if (rsum == wsum) begin
                            state <= LD_RELEASE;
                        end else begin
                            state <= LD_ERROR;
                            err_q <= ERR_CHECKSUM;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
                LD_RELEASE: begin
                    if (rel_zero) begin
                        state    <= LD_RUN;
                        cpu_hold <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a 16x8 instruction memory model.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       prog_enable;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    logic [7:0] mem [16];
    logic [7:0] prog [17];
    logic       clr_mem = 1'b0;
    logic       fault_en = 1'b0;
    int         cyc = 0;
    int         cyc_start = 0;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .prog_enable (prog_enable),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hFF;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Stuck-at-1 on bit 0 of address 3 when the fault is armed.
    assign mem_rdata = mem[mem_addr] | {7'b0, fault_en && (mem_addr == 4'd3)};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc_start = cyc;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        chk(tag, in_ready, 1);
    endtask

    task automatic feed(input string tag, input int n, input bit bp,
                        input bit last_final, input bit poke_start);
        int  i   = 0;
        int  g   = 0;
        int  bad = 0;
        bit  ph  = 1'b0;
        while (i < n && g < 200) begin
            in_valid = bp ? ~ph : 1'b1;
            in_data  = prog[i];
            in_last  = last_final && (i == n - 1);
            start    = poke_start && !in_valid;
            #1;
            if (mem_we !== in_valid || (in_valid && mem_addr !== 4'(i))) bad++;
            if (in_valid) i++;
            ph = ~ph;
            g++;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        chk({tag, "_we"}, bad, 0);
        chk({tag, "_cnt"}, i, n);
    endtask

    task automatic wait_run(output int lat, output int dn, output int gap);
        int pe_c = -1;
        int ch_c = -1;
        int d_c  = -1;
        dn = 0;
        for (int k = 0; k < 100 && ch_c < 0; k++) begin
            tick();
            if (done) begin
                dn++;
                if (d_c < 0) d_c = cyc;
            end
            if (!prog_enable && pe_c < 0) pe_c = cyc;
            if (!cpu_hold && ch_c < 0) ch_c = cyc;
        end
        repeat (3) begin
            tick();
            if (done) dn++;
        end
        chk("run_hold_low", cpu_hold, 0);
        // Cycle numbering: the cycle carrying start is cycle 0.
        lat = d_c - cyc_start + 1;
        gap = ch_c - pe_c;
    endtask

    task automatic wait_err(input string tag);
        int k = 0;
        while (!error && k < 100) begin
            tick();
            k++;
        end
        chk(tag, error, 1);
    endtask

    task automatic mem_chk(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (mem[i] !== prog[i]) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        int lat, dn, gap;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (2) tick();

        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_prog_en", prog_enable, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        reset = 1'b0;
        clear_mem();

        // Basic 12-word load
        for (int i = 0; i < 12; i++) prog[i] = 8'(i);
        pulse_start();
        chk("halt_busy", busy, 1);
        chk("halt_prog_en", prog_enable, 1);
        chk("halt_cpu_hold", cpu_hold, 1);
        chk("halt_in_ready", in_ready, 0);
        wait_ready("basic_ready");
        chk("basic_ready_lat", cyc - cyc_start + 1, 3);
        feed("basic", 12, 1'b0, 1'b1, 1'b0);
        wait_run(lat, dn, gap);
        chk("basic_latency", lat, 29);
        chk("basic_done_once", dn, 1);
        chk("basic_hold_gap", gap, 1);
        chk("basic_wsum", dut.wsum, 8'h42);
        chk("basic_rsum", dut.rsum, 8'h42);
        chk("basic_error", error, 0);
        mem_chk("basic_mem", 12);

        // Reload from RUN with backpressure and ignored start pulses
        clear_mem();
        pulse_start();
        chk("reload_hold", cpu_hold, 1);
        chk("reload_busy", busy, 1);
        wait_ready("bp_ready");
        feed("bp", 12, 1'b1, 1'b1, 1'b1);
        wait_run(lat, dn, gap);
        chk("bp_done_once", dn, 1);
        chk("bp_hold_gap", gap, 1);
        mem_chk("bp_mem", 12);

        // Full depth, legal
        for (int i = 0; i < 16; i++) prog[i] = 8'(i);
        pulse_start();
        wait_ready("full_ready");
        feed("full", 16, 1'b0, 1'b1, 1'b0);
        wait_run(lat, dn, gap);
        chk("full_done_once", dn, 1);
        chk("full_error", error, 0);
        chk("full_wsum", dut.wsum, 8'h78);
        mem_chk("full_mem", 16);

        // Full depth plus one word without in_last
        for (int i = 0; i < 16; i++) prog[i] = 8'hA0 + 8'(i);
        pulse_start();
        wait_ready("ovf_ready");
        feed("ovf", 16, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        chk("ovf_we_blocked", mem_we, 0);
        tick();
        in_valid = 1'b0;
        chk("ovf_error", error, 1);
        chk("ovf_err_code", err_code, 2'b01);
        chk("ovf_cpu_hold", cpu_hold, 1);
        chk("ovf_prog_en", prog_enable, 0);
        chk("ovf_busy", busy, 0);
        tick();
        chk("ovf_mem0", mem[0], 8'hA0);
        mem_chk("ovf_mem", 16);

        // Checksum fault: address 3 holds 0x02, reads back as 0x03
        for (int i = 0; i < 12; i++) prog[i] = (i == 3) ? 8'h02 : 8'(i);
        fault_en = 1'b1;
        pulse_start();
        chk("ck_restart_error", error, 0);
        wait_ready("ck_ready");
        feed("ck", 12, 1'b0, 1'b1, 1'b0);
        wait_err("ck_error");
        chk("ck_err_code", err_code, 2'b10);
        chk("ck_prog_en", prog_enable, 0);
        chk("ck_cpu_hold", cpu_hold, 1);
        fault_en = 1'b0;
        for (int i = 0; i < 3; i++) prog[i] = 8'h30 + 8'(i);
        pulse_start();
        chk("ck_clear_err", err_code, 2'b00);
        chk("ck_clear_error", error, 0);
        wait_ready("ck2_ready");
        feed("ck2", 3, 1'b0, 1'b1, 1'b0);
        wait_run(lat, dn, gap);
        chk("ck2_done_once", dn, 1);
        chk("ck2_latency", lat, 1 + 2 + 3 + 3 + 1 + 1);
        mem_chk("ck2_mem", 3);

        // Reset in the middle of LOAD
        for (int i = 0; i < 5; i++) prog[i] = 8'h50 + 8'(i);
        pulse_start();
        wait_ready("mid_ready");
        feed("mid", 5, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_cpu_hold", cpu_hold, 1);
        chk("mid_in_ready", in_ready, 0);
        chk("mid_busy", busy, 0);
        chk("mid_prog_en", prog_enable, 0);
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) prog[i] = 8'hC0 + 8'(i);
        pulse_start();
        wait_ready("post_ready");
        feed("post", 3, 1'b0, 1'b1, 1'b0);
        wait_run(lat, dn, gap);
        chk("post_done_once", dn, 1);
        chk("post_error", error, 0);
        mem_chk("post_mem", 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
